// File: rtl/mole_pkg.sv
// Shared types and helpers for the whack-a-mole game core.
// Holds the game/mole state encodings, the LFSR tap mask, level codes,
// and the small combinational helpers used by the top.
package mole_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } game_state_t;

  typedef enum logic {
    DOWN = 1'b0,
    UP   = 1'b1
  } mole_state_t;

  // Right-shifting Fibonacci form of x^16+x^14+x^13+x^11: taps on bits 0,2,3,5.
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  localparam logic [1:0] LVL1 = 2'd1;
  localparam logic [1:0] LVL2 = 2'd2;
  localparam logic [1:0] LVL3 = 2'd3;

  // One LFSR step: feedback is the parity of the tapped bits, shifted in at the top.
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {^(v & LFSR_TAPS), v[15:1]};
  endfunction

  // Number of set bits in a 16-bit vector (mole vectors are zero-extended).
  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] c;
    c = 5'd0;
    for (int i = 0; i < 16; i++) begin
      c = c + {4'd0, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/mole_field_if.sv
// Bus between the game core and its surroundings: buttons, time base and
// start request in; electromagnet enables, hit pulses and scoreboard out.
// The slave modport is the game core's view, master is the environment's.
interface mole_field_if #(
  parameter int NUM_MOLES = 3,
  parameter int SCORE_W   = 10,
  parameter int TIMER_W   = 7
);
  logic                 i_tick;
  logic                 i_start;
  logic [NUM_MOLES-1:0] i_bt_mole;
  logic [NUM_MOLES-1:0] o_mole_en;
  logic [NUM_MOLES-1:0] o_hit;
  logic                 o_hit_any;
  logic [SCORE_W-1:0]   o_score;
  logic [1:0]           o_level;
  logic [TIMER_W-1:0]   o_timer;
  logic                 o_playing;
  logic                 o_game_over;

  modport master (
    output i_tick, i_start, i_bt_mole,
    input  o_mole_en, o_hit, o_hit_any, o_score, o_level, o_timer,
           o_playing, o_game_over
  );

  modport slave (
    input  i_tick, i_start, i_bt_mole,
    output o_mole_en, o_hit, o_hit_any, o_score, o_level, o_timer,
           o_playing, o_game_over
  );
endinterface

// File: rtl/mole_cell.sv
// One mole: DOWN/UP state plus an age counter measured in game ticks.
// A rise lifts a DOWN mole; a button press on an UP mole drops it and
// pulses o_hit; reaching UP_TICKS ticks drops it as a miss.
// Optional build macro MOLE_MISS_PENALTY_EN adds the o_miss pulse.
module mole_cell import mole_pkg::*; #(
  parameter int UP_TICKS = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_tick,
  input  logic i_rise,
  input  logic i_btn,
  output logic o_en,
`ifdef MOLE_MISS_PENALTY_EN
  output logic o_miss,
`endif
  output logic o_hit
);

  localparam int AGE_W = (UP_TICKS < 2) ? 1 : $clog2(UP_TICKS + 1);
  // Age value whose next tick completes the up time.
  localparam logic [AGE_W-1:0] AGE_LAST = AGE_W'(UP_TICKS - 1);

  mole_state_t      r_state;
  logic [AGE_W-1:0] r_age;
  logic             r_hit;
`ifdef MOLE_MISS_PENALTY_EN
  logic             r_miss;
`endif

  // Mole state machine: hit has priority over timeout; rise on an UP mole is ignored.
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_state <= DOWN;
      r_age   <= {AGE_W{1'b0}};
      r_hit   <= 1'b0;
`ifdef MOLE_MISS_PENALTY_EN
      r_miss  <= 1'b0;
`endif
    end else begin
      r_hit  <= 1'b0;
`ifdef MOLE_MISS_PENALTY_EN
      r_miss <= 1'b0;
`endif
      case (r_state)
        DOWN: begin
          if (i_rise) begin
            r_state <= UP;
            r_age   <= {AGE_W{1'b0}};
          end
        end
        UP: begin
          if (i_btn) begin
            r_state <= DOWN;
            r_age   <= {AGE_W{1'b0}};
            r_hit   <= 1'b1;
          end else if (i_tick) begin
            if (r_age == AGE_LAST) begin
              r_state <= DOWN;
              r_age   <= {AGE_W{1'b0}};
`ifdef MOLE_MISS_PENALTY_EN
              r_miss  <= 1'b1;
`endif
            end else begin
              r_age <= r_age + AGE_W'(1);
            end
          end
        end
        default: begin
          r_state <= DOWN;
          r_age   <= {AGE_W{1'b0}};
        end
      endcase
    end
  end

  assign o_en  = (r_state == DOWN);
  assign o_hit = r_hit;
`ifdef MOLE_MISS_PENALTY_EN
  assign o_miss = r_miss;
`endif

endmodule

// File: rtl/mole_field.sv
// Whack-a-mole game core: game FSM, tick timer, free-running LFSR, rise
// decoder, per-mole cells and the saturating score adder.
// Optional build macro MOLE_MISS_PENALTY_EN: each auto-drop costs one point
// (score floors at 0); without it misses do not touch the score.
module mole_field import mole_pkg::*; #(
  parameter int          NUM_MOLES  = 3,
  parameter int          SCORE_W    = 10,
  parameter int          TIMER_W    = 7,
  parameter int          GAME_TICKS = 60,
  parameter int          UP_TICKS   = 2,
  parameter int          L2_SCORE   = 20,
  parameter int          L3_SCORE   = 50,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input logic         clk,
  input logic         rst,
  mole_field_if.slave bus
);

  localparam int                 SW2        = SCORE_W + 2;
  localparam logic [SCORE_W-1:0] SCORE_MAX  = {SCORE_W{1'b1}};
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(GAME_TICKS - 1);
  localparam logic [15:0]        NM16       = 16'(NUM_MOLES);
  localparam logic [4:0]         NM5        = 5'(NUM_MOLES);

  game_state_t          r_state;
  logic [TIMER_W-1:0]   r_timer;
  logic [SCORE_W-1:0]   r_score;
  logic [15:0]          r_lfsr;
  logic                 r_playing;
  logic                 r_game_over;

  logic                 w_game_tick;
  logic                 w_last;
  logic                 w_step;
  logic                 w_clr;
  logic [1:0]           w_level;
  logic [4:0]           w_base;
  logic [4:0]           w_cnt;
  logic [4:0]           w_off;
  logic [NUM_MOLES-1:0] w_rise;
  logic [NUM_MOLES-1:0] w_en;
  logic [NUM_MOLES-1:0] w_hit;
  logic [4:0]           w_hit_cnt;
  logic [SW2-1:0]       w_sum;
  logic [SCORE_W-1:0]   w_score_nx;
`ifdef MOLE_MISS_PENALTY_EN
  logic [NUM_MOLES-1:0] w_miss;
  logic [4:0]           w_miss_cnt;
`endif

  // Only ticks seen in PLAY count; the final tick ends the game and issues no rise.
  assign w_game_tick = (r_state == PLAY) && bus.i_tick;
  assign w_last      = w_game_tick && (r_timer == TIMER_LAST);
  assign w_step      = w_game_tick && !w_last;
  assign w_clr       = (r_state != PLAY) || w_last;

  // Level follows the current score directly.
  always_comb begin
    if (r_score >= SCORE_W'(L3_SCORE)) begin
      w_level = LVL3;
    end else if (r_score >= SCORE_W'(L2_SCORE)) begin
      w_level = LVL2;
    end else begin
      w_level = LVL1;
    end
  end

  // Rise decoder: min(level, NUM_MOLES) consecutive moles from lfsr % NUM_MOLES, wrapping.
  always_comb begin
    w_base = 5'(r_lfsr % NM16);
    if ({3'b000, w_level} > NM5) begin
      w_cnt = NM5;
    end else begin
      w_cnt = {3'b000, w_level};
    end
    w_off  = 5'd0;
    w_rise = {NUM_MOLES{1'b0}};
    for (int i = 0; i < NUM_MOLES; i++) begin
      w_off = 5'(i) + NM5 - w_base;
      if (w_off >= NM5) begin
        w_off = w_off - NM5;
      end else begin
        w_off = w_off;
      end
      w_rise[i] = w_step && (w_off < w_cnt);
    end
  end

  for (genvar g = 0; g < NUM_MOLES; g++) begin : g_mole
    mole_cell #(
      .UP_TICKS(UP_TICKS)
    ) u_cell (
      .clk    (clk),
      .rst    (rst),
      .i_clr  (w_clr),
      .i_tick (w_step),
      .i_rise (w_rise[g]),
      .i_btn  (bus.i_bt_mole[g]),
      .o_en   (w_en[g]),
`ifdef MOLE_MISS_PENALTY_EN
      .o_miss (w_miss[g]),
`endif
      .o_hit  (w_hit[g])
    );
  end

  assign w_hit_cnt = popcount16(16'(w_hit));
`ifdef MOLE_MISS_PENALTY_EN
  assign w_miss_cnt = popcount16(16'(w_miss));
`endif

  // Next score: add hits (minus misses when penalised), clamp to [0, SCORE_MAX].
  always_comb begin
    w_sum = {2'b00, r_score} + SW2'(w_hit_cnt);
`ifdef MOLE_MISS_PENALTY_EN
    if (w_sum < SW2'(w_miss_cnt)) begin
      w_sum = {SW2{1'b0}};
    end else begin
      w_sum = w_sum - SW2'(w_miss_cnt);
    end
`endif
    if (w_sum > {2'b00, SCORE_MAX}) begin
      w_score_nx = SCORE_MAX;
    end else begin
      w_score_nx = w_sum[SCORE_W-1:0];
    end
  end

  // Game FSM with timer, score and the registered playing/game_over flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_timer     <= {TIMER_W{1'b0}};
      r_score     <= {SCORE_W{1'b0}};
      r_playing   <= 1'b0;
      r_game_over <= 1'b0;
    end else begin
      case (r_state)
        IDLE, OVER: begin
          if (bus.i_start) begin
            r_state     <= PLAY;
            r_timer     <= {TIMER_W{1'b0}};
            r_score     <= {SCORE_W{1'b0}};
            r_playing   <= 1'b1;
            r_game_over <= 1'b0;
          end
        end
        PLAY: begin
          r_score <= w_score_nx;
          if (w_game_tick) begin
            r_timer <= r_timer + TIMER_W'(1);
            if (w_last) begin
              r_state     <= OVER;
              r_playing   <= 1'b0;
              r_game_over <= 1'b1;
            end
          end
        end
        default: begin
          r_state     <= IDLE;
          r_playing   <= 1'b0;
          r_game_over <= 1'b0;
        end
      endcase
    end
  end

  // Free-running pattern source; advances every cycle in every state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lfsr <= LFSR_SEED;
    end else begin
      r_lfsr <= lfsr_next(r_lfsr);
    end
  end

  assign bus.o_mole_en   = w_en;
  assign bus.o_hit       = w_hit;
  assign bus.o_hit_any   = |w_hit;
  assign bus.o_score     = r_score;
  assign bus.o_level     = w_level;
  assign bus.o_timer     = r_timer;
  assign bus.o_playing   = r_playing;
  assign bus.o_game_over = r_game_over;

endmodule

// File: tb/tb_mole_field.sv
// Directed bench for mole_field (NUM_MOLES=3, UP_TICKS=2, GAME_TICKS=60).
// A local LFSR copy tells the bench which mole base a tick will pick.
module tb_mole_field;

  localparam int          NM   = 3;
  localparam int          SW   = 10;
  localparam int          TW   = 7;
  localparam logic [15:0] SEED = 16'hACE1;

  logic        clk;
  logic        rst;
  int          n_total;
  int          n_bad;
  logic [15:0] m_lfsr;
  int          exp_score;
  int          exp_timer;
  int          b;
  int          inc;

  mole_field_if #(.NUM_MOLES(NM), .SCORE_W(SW), .TIMER_W(TW)) bus ();

  mole_field #(
    .NUM_MOLES (NM),
    .SCORE_W   (SW),
    .TIMER_W   (TW),
    .GAME_TICKS(60),
    .UP_TICKS  (2),
    .L2_SCORE  (20),
    .L3_SCORE  (50),
    .LFSR_SEED (SEED)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    logic fb;
    fb = v[0] ^ v[2] ^ v[3] ^ v[5];
    return {fb, v[15:1]};
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One clock; outputs are stable when this returns (1 time unit after the edge).
  task automatic step();
    logic was_rst;
    was_rst = rst;
    @(posedge clk);
    #1;
    if (was_rst) m_lfsr = SEED;
    else         m_lfsr = lfsr_step(m_lfsr);
  endtask

  task automatic do_tick(input bit in_play);
    bus.i_tick = 1'b1;
    step();
    bus.i_tick = 1'b0;
    if (in_play) exp_timer++;
  endtask

  // Wait (bounded) until the LFSR picks the wanted base, then tick.
  task automatic tick_at(input int base);
    int n;
    n = 0;
    while (((int'(m_lfsr) % NM) != base) && (n < 64)) begin
      step();
      n++;
    end
    check_val("tick_wait", 32'(n < 64), 32'd1);
    do_tick(1'b1);
  endtask

  initial begin
    n_total = 0; n_bad = 0; exp_score = 0; exp_timer = 0; m_lfsr = SEED;
    rst = 1'b1; bus.i_tick = 1'b0; bus.i_start = 1'b0; bus.i_bt_mole = 3'b000;
    step(); step();
    rst = 1'b0;

    // 1: reset state, then ticks without start change nothing
    check_val("rst_en", bus.o_mole_en, 32'h7);
    check_val("rst_hit", bus.o_hit, 32'h0);
    check_val("rst_score", bus.o_score, 32'd0);
    check_val("rst_timer", bus.o_timer, 32'd0);
    check_val("rst_level", bus.o_level, 32'd1);
    check_val("rst_playing", bus.o_playing, 32'd0);
    check_val("rst_over", bus.o_game_over, 32'd0);
    repeat (100) do_tick(1'b0);
    check_val("idle_en", bus.o_mole_en, 32'h7);
    check_val("idle_timer", bus.o_timer, 32'd0);
    check_val("idle_score", bus.o_score, 32'd0);
    check_val("idle_playing", bus.o_playing, 32'd0);

    // 2: start, rise mole 1, hit it, holding the button gives one hit only
    bus.i_start = 1'b1; step(); bus.i_start = 1'b0;
    check_val("start_playing", bus.o_playing, 32'd1);
    tick_at(1);
    check_val("rise1_en", bus.o_mole_en, 32'h5);
    bus.i_bt_mole = 3'b010; step();
    check_val("hit1", bus.o_hit, 32'h2);
    check_val("hit1_any", bus.o_hit_any, 32'd1);
    check_val("hit1_en", bus.o_mole_en, 32'h7);
    check_val("hit1_score_lag", bus.o_score, 32'd0);
    step();
    check_val("hit1_pulse_end", bus.o_hit, 32'h0);
    check_val("hit1_score", bus.o_score, 32'd1);
    step();
    check_val("held_no_rehit", bus.o_hit, 32'h0);
    check_val("held_score", bus.o_score, 32'd1);
    bus.i_bt_mole = 3'b000;
    exp_score = 1;

    // 3: two unpressed rises of mole 0 time out after 2 ticks each
    for (int r = 0; r < 2; r++) begin
      tick_at(0);
      check_val("miss_up0", bus.o_mole_en, 32'h6);
      tick_at(0);
      check_val("miss_up1", bus.o_mole_en, 32'h6);
      tick_at(0);
      check_val("miss_drop", bus.o_mole_en, 32'h7);
      step();
`ifdef MOLE_MISS_PENALTY_EN
      if (exp_score > 0) exp_score--;
`endif
      check_val("miss_score", bus.o_score, 32'(exp_score));
    end
    check_val("miss_timer", bus.o_timer, 32'(exp_timer));

    // 4: single hits up to score 20 (level 2), then a wrapping double rise
    while (exp_score < 20) begin
      check_val("l1_level", bus.o_level, 32'd1);
      b = int'(m_lfsr) % NM;
      do_tick(1'b1);
      check_val("l1_en", bus.o_mole_en, 32'(7 & ~(1 << b)));
      bus.i_bt_mole = 3'(1 << b); step(); bus.i_bt_mole = 3'b000;
      check_val("l1_hit", bus.o_hit, 32'(1 << b));
      step();
      exp_score++;
      check_val("l1_score", bus.o_score, 32'(exp_score));
    end
    check_val("l2_level", bus.o_level, 32'd2);
    tick_at(2);
    check_val("l2_wrap_en", bus.o_mole_en, 32'h2);
    bus.i_bt_mole = 3'b101; step(); bus.i_bt_mole = 3'b000;
    check_val("l2_dual_hit", bus.o_hit, 32'h5);
    check_val("l2_dual_any", bus.o_hit_any, 32'd1);
    step();
    exp_score += 2;
    check_val("l2_dual_score", bus.o_score, 32'(exp_score));

    // 5: run the game out with all buttons held; each rise is hit exactly once
    bus.i_bt_mole = 3'b111;
    while (exp_timer < 59) begin
      inc = (exp_score >= 50) ? 3 : 2;
      do_tick(1'b1); step(); step();
      exp_score += inc;
      check_val("run_score", bus.o_score, 32'(exp_score));
      step();
    end
    check_val("run_level3", bus.o_level, 32'd3);
    do_tick(1'b1);
    check_val("over_flag", bus.o_game_over, 32'd1);
    check_val("over_playing", bus.o_playing, 32'd0);
    check_val("over_timer", bus.o_timer, 32'd60);
    check_val("over_en", bus.o_mole_en, 32'h7);
    do_tick(1'b0); step(); step();
    check_val("over_hold_timer", bus.o_timer, 32'd60);
    check_val("over_hold_score", bus.o_score, 32'(exp_score));
    check_val("over_no_hit", bus.o_hit, 32'h0);
    check_val("over_hold_en", bus.o_mole_en, 32'h7);
    bus.i_bt_mole = 3'b000;
    bus.i_start = 1'b1; step(); bus.i_start = 1'b0;
    exp_score = 0; exp_timer = 0;
    check_val("restart_playing", bus.o_playing, 32'd1);
    check_val("restart_over", bus.o_game_over, 32'd0);
    check_val("restart_score", bus.o_score, 32'd0);
    check_val("restart_timer", bus.o_timer, 32'd0);
    check_val("restart_level", bus.o_level, 32'd1);

    // 6: score a point, start in PLAY is ignored, then reset mid-game
    b = int'(m_lfsr) % NM;
    do_tick(1'b1);
    check_val("g2_en", bus.o_mole_en, 32'(7 & ~(1 << b)));
    bus.i_bt_mole = 3'(1 << b); step(); bus.i_bt_mole = 3'b000;
    check_val("g2_hit", bus.o_hit, 32'(1 << b));
    step();
    check_val("g2_score", bus.o_score, 32'd1);
    bus.i_start = 1'b1; step(); bus.i_start = 1'b0;
    check_val("start_in_play_score", bus.o_score, 32'd1);
    check_val("start_in_play_timer", bus.o_timer, 32'd1);
    b = int'(m_lfsr) % NM;
    do_tick(1'b1);
    check_val("pre_rst_en", bus.o_mole_en, 32'(7 & ~(1 << b)));
    rst = 1'b1; step();
    check_val("midrst_en", bus.o_mole_en, 32'h7);
    check_val("midrst_score", bus.o_score, 32'd0);
    check_val("midrst_timer", bus.o_timer, 32'd0);
    check_val("midrst_playing", bus.o_playing, 32'd0);
    check_val("midrst_over", bus.o_game_over, 32'd0);
    check_val("midrst_hit", bus.o_hit, 32'h0);
    rst = 1'b0; exp_timer = 0;
    bus.i_start = 1'b1; step(); bus.i_start = 1'b0;
    b = int'(m_lfsr) % NM;
    do_tick(1'b1);
    check_val("post_rst_seed_en", bus.o_mole_en, 32'(7 & ~(1 << b)));
    check_val("post_rst_timer", bus.o_timer, 32'(exp_timer));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
